// File: rtl/gf_mul_serial.sv
// Digit-serial GF(2^DWIDTH) multiplier, Horner MSB-first, runtime reduction polynomial.
// Optional GMUL_SQR_EN macro adds a sqr input that selects a as the multiplier (squaring).
module gf_mul_serial #(
   parameter int DWIDTH = 8,
   parameter int DIGIT  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef GMUL_SQR_EN
   input  logic              sqr,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] a,
   input  logic [DWIDTH-1:0] b,
   input  logic [DWIDTH-1:0] m,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] p,
   output logic              busy
);

   localparam int STEPS = DWIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DWIDTH-1:0] a_q, a_d;
   logic [DWIDTH-1:0] b_q, b_d;
   logic [DWIDTH-1:0] m_q, m_d;
   logic [DWIDTH-1:0] acc_q, acc_d;
   logic [DWIDTH-1:0] p_q, p_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DWIDTH-1:0] acc_step;
   logic [DWIDTH-1:0] mult_sel;
   logic              accept;
   logic              cnt_last;

   function automatic logic [DWIDTH-1:0] mul2(input logic [DWIDTH-1:0] x,
                                              input logic [DWIDTH-1:0] poly);
      return {x[DWIDTH-2:0], 1'b0} ^ (poly & {DWIDTH{x[DWIDTH-1]}});
   endfunction

   assign in_ready  = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN);
   assign p         = p_q;
   assign cnt_last  = (cnt_q == CW'(STEPS - 1));

`ifdef GMUL_SQR_EN
   assign mult_sel = sqr ? a : b;
`else
   assign mult_sel = b;
`endif

   // b_q is shifted left each cycle, so the next multiplier digit is always at the top.
   always_comb begin
      acc_step = acc_q;
      for (int i = 0; i < DIGIT; i++) begin
         acc_step = mul2(acc_step, m_q) ^ (b_q[DWIDTH-1-i] ? a_q : '0);
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      m_d     = m_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      case (state_q)
         S_IDLE: ;
         S_RUN: begin
            acc_d = acc_step;
            b_d   = b_q << DIGIT;
            if (cnt_last) begin
               p_d     = acc_step;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Accept overrides the DONE->IDLE exit so back-to-back operands skip IDLE.
      if (accept) begin
         a_d     = a;
         b_d     = mult_sel;
         m_d     = m;
         acc_d   = '0;
         cnt_d   = '0;
         state_d = S_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
   end

endmodule

// File: tb/tb_gf_mul_serial.sv
// Scoreboard bench for gf_mul_serial: DIGIT=1 and DIGIT=4 instances, LSB-first reference model.
module tb_gf_mul_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0] a, b, m, p;
   logic       d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready, d4_busy;
   logic [7:0] d4_a, d4_b, d4_m, d4_p;
`ifdef GMUL_SQR_EN
   logic       sqr;
   logic       d4_sqr;
`endif

   int         vectors = 0;
   int         errors  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp4_q[$];

   always #5 clk = ~clk;

   gf_mul_serial #(.DWIDTH(8), .DIGIT(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
`ifdef GMUL_SQR_EN
      .sqr(sqr),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .m(m),
      .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
   );

   gf_mul_serial #(.DWIDTH(8), .DIGIT(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
`ifdef GMUL_SQR_EN
      .sqr(d4_sqr),
`endif
      .in_valid(d4_in_valid), .in_ready(d4_in_ready), .a(d4_a), .b(d4_b), .m(d4_m),
      .out_valid(d4_out_valid), .out_ready(d4_out_ready), .p(d4_p), .busy(d4_busy)
   );

   // Shift-and-add from the LSB of b, reducing a each step (opposite order to the DUT).
   function automatic logic [7:0] gf_ref(input logic [7:0] fa, input logic [7:0] fb,
                                         input logic [7:0] fm);
      logic [7:0] r, x;
      r = 8'h00;
      x = fa;
      for (int i = 0; i < 8; i++) begin
         if (fb[i]) r = r ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? fm : 8'h00);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] im);
      bit ok;
      ok = 0;
      in_valid = 1'b1;
      a = ia; b = ib; m = im;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (in_ready) begin
            exp_q.push_back(gf_ref(ia, ib, im));
            ok = 1;
         end
         tick();
      end
      in_valid = 1'b0;
      vectors++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout: in_ready got 0 want 1 within 50 cycles");
      end
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick(); tick();
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      vectors++; if (p !== 8'h00) begin errors++; $display("FAIL rst_p: got %h want 00", p); end
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      rst_n = 1'b1;
      tick();
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_vectors();
      logic [7:0] ta[6] = '{8'h57, 8'h57, 8'h80, 8'h57, 8'hCA, 8'hFF};
      logic [7:0] tb[6] = '{8'h83, 8'h13, 8'h02, 8'h83, 8'h53, 8'hFF};
      logic [7:0] tm[6] = '{8'h1B, 8'h1B, 8'h1B, 8'h00, 8'h1B, 8'h1B};
      logic [7:0] tp[6] = '{8'hC1, 8'hFE, 8'h1B, 8'h79, 8'h01, 8'h13};
      logic [7:0] exp;
      int cyc;
      for (int k = 0; k < 10; k++) begin
         if (k < 6) issue(ta[k], tb[k], tm[k]);
         else issue(8'($urandom), 8'($urandom), 8'($urandom));
         vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL vec%0d_busy: got %b want 1", k, busy); end
         wait_out(cyc);
         vectors++; if (cyc != 8) begin errors++; $display("FAIL vec%0d_latency: got %0d want 8", k, cyc); end
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
         vectors++; if (p !== exp) begin errors++; $display("FAIL vec%0d_p: got %h want %h", k, p, exp); end
         if (k < 6) begin
            vectors++; if (p !== tp[k]) begin errors++; $display("FAIL vec%0d_known: got %h want %h", k, p, tp[k]); end
         end
         consume();
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [7:0] exp;
      issue(8'h57, 8'h83, 8'h1B);
      wait_out(cyc);
      for (int k = 0; k < 5; k++) begin
         vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid: got %b want 1", k, out_valid); end
         vectors++; if (p !== exp_q[0]) begin errors++; $display("FAIL bp%0d_p: got %h want %h", k, p, exp_q[0]); end
         vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready: got %b want 0", k, in_ready); end
         tick();
      end
      in_valid = 1'b1; a = 8'h02; b = 8'h02; m = 8'h1B;
      out_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++; if (p !== 8'hC1) begin errors++; $display("FAIL bp_first_p: got %h want c1 (%h)", p, exp); end
      exp_q.push_back(gf_ref(8'h02, 8'h02, 8'h1B));
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      vectors++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_straight_run: busy %b out_valid %b want 1 0", busy, out_valid); end
      wait_out(cyc);
      vectors++; if (cyc != 8) begin errors++; $display("FAIL bp_second_latency: got %0d want 8", cyc); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++; if (p !== exp || p !== 8'h04) begin errors++; $display("FAIL bp_second_p: got %h want %h", p, exp); end
      consume();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      int last = -1;
      int nres = 0;
      bit acc;
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = 8'($urandom); b = 8'($urandom); m = 8'($urandom);
      for (int c = 0; c < 45; c++) begin
         if (out_valid) begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            vectors++; if (p !== exp) begin errors++; $display("FAIL b2b_p%0d: got %h want %h", nres, p, exp); end
            if (last >= 0) begin
               vectors++; if (c - last != 9) begin errors++; $display("FAIL b2b_interval%0d: got %0d want 9", nres, c - last); end
            end
            last = c;
            nres++;
         end
         acc = in_ready;
         if (acc) exp_q.push_back(gf_ref(a, b, m));
         tick();
         if (acc) begin a = 8'($urandom); b = 8'($urandom); m = 8'($urandom); end
      end
      in_valid = 1'b0;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         if (out_valid) begin
            exp = exp_q.pop_front();
            vectors++; if (p !== exp) begin errors++; $display("FAIL b2b_drain_p: got %h want %h", p, exp); end
            nres++;
         end
         tick();
      end
      out_ready = 1'b0;
      vectors++; if (nres < 5 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_count: got %0d results (%0d pending) want >=5 and 0", nres, exp_q.size()); end
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      logic [7:0] exp;
      issue(8'h57, 8'h83, 8'h1B);
      tick(); tick();
      rst_n = 1'b0;
      tick();
      vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: out_valid %b busy %b want 0 0", out_valid, busy); end
      vectors++; if (p !== 8'h00) begin errors++; $display("FAIL midrst_p: got %h want 00", p); end
      exp_q.delete();
      rst_n = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: in_ready got %b want 1", in_ready); end
      issue(8'h57, 8'h13, 8'h1B);
      wait_out(cyc);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++; if (p !== exp || p !== 8'hFE) begin errors++; $display("FAIL midrst_fresh_p: got %h want %h", p, exp); end
      consume();
   endtask

   task automatic test_operand_change();
      int cyc = 0;
      logic [7:0] exp;
      issue(8'hCA, 8'h53, 8'h1B);
      while (!out_valid && cyc < 40) begin
         a = 8'($urandom); b = 8'($urandom); m = 8'($urandom);
         tick();
         cyc++;
      end
      vectors++; if (cyc != 8) begin errors++; $display("FAIL opchg_latency: got %0d want 8", cyc); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++; if (p !== exp || p !== 8'h01) begin errors++; $display("FAIL opchg_p: got %h want %h", p, exp); end
      consume();
   endtask

   task automatic test_digit4();
      logic [7:0] ta[4] = '{8'h57, 8'h57, 8'h80, 8'h3C};
      logic [7:0] tb[4] = '{8'h83, 8'h13, 8'h02, 8'hA7};
      logic [7:0] tm[4] = '{8'h1B, 8'h1B, 8'h1B, 8'h2D};
      logic [7:0] exp;
      int cyc;
      for (int k = 0; k < 4; k++) begin
         d4_in_valid = 1'b1; d4_a = ta[k]; d4_b = tb[k]; d4_m = tm[k];
         vectors++; if (d4_in_ready !== 1'b1) begin errors++; $display("FAIL d4_%0d_in_ready: got %b want 1", k, d4_in_ready); end
         exp4_q.push_back(gf_ref(ta[k], tb[k], tm[k]));
         tick();
         d4_in_valid = 1'b0;
         cyc = 0;
         while (!d4_out_valid && cyc < 20) begin tick(); cyc++; end
         vectors++; if (cyc != 2) begin errors++; $display("FAIL d4_%0d_latency: got %0d want 2", k, cyc); end
         exp = (exp4_q.size() != 0) ? exp4_q.pop_front() : 8'hxx;
         vectors++; if (d4_p !== exp) begin errors++; $display("FAIL d4_%0d_p: got %h want %h", k, d4_p, exp); end
         d4_out_ready = 1'b1;
         tick();
         d4_out_ready = 1'b0;
      end
   endtask

`ifdef GMUL_SQR_EN
   task automatic test_sqr();
      int cyc;
      logic [7:0] exp;
      sqr = 1'b1;
      in_valid = 1'b1; a = 8'h57; b = 8'hFF; m = 8'h1B;
      exp_q.push_back(gf_ref(8'h57, 8'h57, 8'h1B));
      tick();
      in_valid = 1'b0; sqr = 1'b0;
      wait_out(cyc);
      vectors++; if (cyc != 8) begin errors++; $display("FAIL sqr_latency: got %0d want 8", cyc); end
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++; if (p !== exp || p !== 8'hA5) begin errors++; $display("FAIL sqr_p: got %h want %h", p, exp); end
      consume();
      issue(8'h57, 8'h83, 8'h1B);
      wait_out(cyc);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      vectors++; if (p !== exp || p !== 8'hC1) begin errors++; $display("FAIL sqr_off_p: got %h want %h", p, exp); end
      consume();
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      a = 8'h00; b = 8'h00; m = 8'h00;
      d4_in_valid = 1'b0; d4_out_ready = 1'b0;
      d4_a = 8'h00; d4_b = 8'h00; d4_m = 8'h00;
`ifdef GMUL_SQR_EN
      sqr = 1'b0; d4_sqr = 1'b0;
`endif
      test_reset();
      test_vectors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      test_operand_change();
      test_digit4();
`ifdef GMUL_SQR_EN
      test_sqr();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
